// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired T-state control unit: fetch (T0-T2) then
//               opcode-driven execute (T3-T7) producing datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        Stop,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        Illegal
);

  localparam logic [4:0] c_op_ld   = 5'b00000;
  localparam logic [4:0] c_op_ldi  = 5'b00001;
  localparam logic [4:0] c_op_st   = 5'b00010;
  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_addi = 5'b01100;
  localparam logic [4:0] c_op_andi = 5'b01101;
  localparam logic [4:0] c_op_ori  = 5'b01110;
  localparam logic [4:0] c_op_nop  = 5'b11010;
  localparam logic [4:0] c_op_halt = 5'b11011;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [4:0] opcode;
  logic       ir_unused;
  logic       is_ld;
  logic       is_ldi;
  logic       is_st;
  logic       is_alu_rr;
  logic       is_alu_imm;
  logic       is_nop;
  logic       is_halt;
  logic       is_mem_addr;
  logic [4:0] imm_alu_op;

  assign opcode    = ir[31:27];
  assign ir_unused = ^ir[26:0];

  assign is_ld       = (opcode == c_op_ld);
  assign is_ldi      = (opcode == c_op_ldi);
  assign is_st       = (opcode == c_op_st);
  assign is_alu_rr   = (opcode == c_op_add) || (opcode == c_op_sub) ||
                       (opcode == c_op_and) || (opcode == c_op_or);
  assign is_alu_imm  = (opcode == c_op_addi) || (opcode == c_op_andi) ||
                       (opcode == c_op_ori);
  assign is_nop      = (opcode == c_op_nop);
  assign is_halt     = (opcode == c_op_halt);
  // ld/ldi/st share the base-plus-offset address calculation in T3-T4
  assign is_mem_addr = is_ld || is_ldi || is_st;

  always_comb begin
    imm_alu_op = c_op_add;
    if (opcode == c_op_andi) begin
      imm_alu_op = c_op_and;
    end else if (opcode == c_op_ori) begin
      imm_alu_op = c_op_or;
    end
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    IRin    = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    alu_op  = 5'b00000;
    Run     = 1'b1;
    Illegal = 1'b0;

    case (state_q)
      S_RST: begin
        state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = Stop ? S_HALT : S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_mem_addr) begin
          Grb     = 1'b1;
          BAout   = 1'b1;
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_alu_rr || is_alu_imm) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_nop) begin
          state_d = S_T0;
        end else begin
          Illegal = 1'b1;
          state_d = S_T0;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (is_mem_addr) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          alu_op = c_op_add;
        end else if (is_alu_rr) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (is_alu_imm) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          alu_op = imm_alu_op;
        end else begin
          state_d = S_T0;
        end
      end
      S_T5: begin
        state_d = S_T0;
        if (is_ld || is_st) begin
          Zlowout = 1'b1;
          MARin   = 1'b1;
          state_d = S_T6;
        end else if (is_ldi || is_alu_rr || is_alu_imm) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      S_T6: begin
        state_d = S_T7;
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (is_st) begin
          // MDR is loaded from the register file, not memory
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        state_d = S_T0;
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      S_HALT: begin
        Run     = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  typedef logic [18:0] strb_t;

  localparam strb_t M_PCOUT   = 19'd1 << 18;
  localparam strb_t M_MARIN   = 19'd1 << 17;
  localparam strb_t M_INCPC   = 19'd1 << 16;
  localparam strb_t M_PCIN    = 19'd1 << 15;
  localparam strb_t M_IRIN    = 19'd1 << 14;
  localparam strb_t M_READ    = 19'd1 << 13;
  localparam strb_t M_WRITE   = 19'd1 << 12;
  localparam strb_t M_MDRIN   = 19'd1 << 11;
  localparam strb_t M_MDROUT  = 19'd1 << 10;
  localparam strb_t M_YIN     = 19'd1 << 9;
  localparam strb_t M_ZIN     = 19'd1 << 8;
  localparam strb_t M_ZLOWOUT = 19'd1 << 7;
  localparam strb_t M_COUT    = 19'd1 << 6;
  localparam strb_t M_GRA     = 19'd1 << 5;
  localparam strb_t M_GRB     = 19'd1 << 4;
  localparam strb_t M_GRC     = 19'd1 << 3;
  localparam strb_t M_RIN     = 19'd1 << 2;
  localparam strb_t M_ROUT    = 19'd1 << 1;
  localparam strb_t M_BAOUT   = 19'd1 << 0;
  localparam strb_t M_NONE    = 19'd0;

  localparam strb_t E_T0     = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam strb_t E_T1     = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam strb_t E_T2     = M_MDROUT | M_IRIN;
  localparam strb_t E_T3_MEM = M_GRB | M_BAOUT | M_YIN;
  localparam strb_t E_T3_ALU = M_GRB | M_ROUT | M_YIN;
  localparam strb_t E_T4_IMM = M_COUT | M_ZIN;
  localparam strb_t E_T4_RR  = M_GRC | M_ROUT | M_ZIN;
  localparam strb_t E_WB     = M_ZLOWOUT | M_GRA | M_RIN;

  logic        Clock;
  logic        clear;
  logic [31:0] ir;
  logic        Stop;
  logic        PCout, MARin, IncPC, PCin, IRin;
  logic        Read, Write, MDRin, MDRout;
  logic        Yin, Zin, Zlowout, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_op;
  logic        Run;
  logic        Illegal;

  int checks   = 0;
  int failures = 0;

  control_sequencer dut (
    .Clock   (Clock),
    .clear   (clear),
    .ir      (ir),
    .Stop    (Stop),
    .PCout   (PCout),
    .MARin   (MARin),
    .IncPC   (IncPC),
    .PCin    (PCin),
    .IRin    (IRin),
    .Read    (Read),
    .Write   (Write),
    .MDRin   (MDRin),
    .MDRout  (MDRout),
    .Yin     (Yin),
    .Zin     (Zin),
    .Zlowout (Zlowout),
    .Cout    (Cout),
    .Gra     (Gra),
    .Grb     (Grb),
    .Grc     (Grc),
    .Rin     (Rin),
    .Rout    (Rout),
    .BAout   (BAout),
    .alu_op  (alu_op),
    .Run     (Run),
    .Illegal (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare the current cycle's outputs, then advance one clock edge.
  task automatic cyc(input string tag, input strb_t s, input logic [4:0] a,
                     input logic run, input logic ill);
    logic [26:0] obs;
    logic [26:0] exp;
    #2;
    obs = {PCout, MARin, IncPC, PCin, IRin, Read, Write, MDRin, MDRout,
           Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
           alu_op, Run, Illegal};
    exp = {s, a, run, ill};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_T0"}, E_T0, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T1"}, E_T1, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T2"}, E_T2, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic run_alu_imm(input string tag, input logic [4:0] op,
                             input logic [4:0] exp_alu);
    ir = {op, 27'h0};
    fetch(tag);
    cyc({tag, "_T3"}, E_T3_ALU, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T4"}, E_T4_IMM, exp_alu, 1'b1, 1'b0);
    cyc({tag, "_T5"}, E_WB, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic run_alu_rr(input string tag, input logic [4:0] op);
    ir = {op, 27'h155_5555};
    fetch(tag);
    cyc({tag, "_T3"}, E_T3_ALU, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T4"}, E_T4_RR, op, 1'b1, 1'b0);
    cyc({tag, "_T5"}, E_WB, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic run_ld(input string tag);
    ir = {5'b00000, 27'h7ff_ffff};
    fetch(tag);
    cyc({tag, "_T3"}, E_T3_MEM, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T4"}, E_T4_IMM, 5'b00011, 1'b1, 1'b0);
    cyc({tag, "_T5"}, M_ZLOWOUT | M_MARIN, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T6"}, M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0);
    cyc({tag, "_T7"}, M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    clear = 1'b0;
    Stop  = 1'b0;
    ir    = 32'h0;
    @(posedge Clock);
    #1;
    cyc("rst_hold", M_NONE, 5'd0, 1'b1, 1'b0);
    clear = 1'b1;
    cyc("rst_exit", M_NONE, 5'd0, 1'b1, 1'b0);

    // Load: full 8-state path; the next fetch's T0 closes the 8-cycle loop
    run_ld("ld");

    run_alu_rr("add", 5'b00011);
    run_alu_rr("sub", 5'b00100);
    run_alu_rr("and", 5'b00101);

    // Store
    ir = {5'b00010, 27'h0};
    fetch("st");
    cyc("st_T3", E_T3_MEM, 5'd0, 1'b1, 1'b0);
    cyc("st_T4", E_T4_IMM, 5'b00011, 1'b1, 1'b0);
    cyc("st_T5", M_ZLOWOUT | M_MARIN, 5'd0, 1'b1, 1'b0);
    cyc("st_T6", M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1, 1'b0);
    cyc("st_T7", M_WRITE, 5'd0, 1'b1, 1'b0);

    // Load immediate
    ir = {5'b00001, 27'h0};
    fetch("ldi");
    cyc("ldi_T3", E_T3_MEM, 5'd0, 1'b1, 1'b0);
    cyc("ldi_T4", E_T4_IMM, 5'b00011, 1'b1, 1'b0);
    cyc("ldi_T5", E_WB, 5'd0, 1'b1, 1'b0);

    run_alu_imm("addi", 5'b01100, 5'b00011);
    run_alu_imm("andi", 5'b01101, 5'b00101);
    run_alu_imm("ori",  5'b01110, 5'b00110);

    // nop, with Stop raised outside T0 to show it is ignored there
    ir = {5'b11010, 27'h0};
    cyc("nop_T0", E_T0, 5'd0, 1'b1, 1'b0);
    Stop = 1'b1;
    cyc("nop_T1_stop", E_T1, 5'd0, 1'b1, 1'b0);
    cyc("nop_T2_stop", E_T2, 5'd0, 1'b1, 1'b0);
    cyc("nop_T3_stop", M_NONE, 5'd0, 1'b1, 1'b0);
    Stop = 1'b0;

    // Undefined opcode
    ir = {5'b11111, 27'h0};
    fetch("ill");
    cyc("ill_T3", M_NONE, 5'd0, 1'b1, 1'b1);
    ir = {5'b11010, 27'h0};
    cyc("ill_next_T0", E_T0, 5'd0, 1'b1, 1'b0);
    cyc("nop2_T1", E_T1, 5'd0, 1'b1, 1'b0);
    cyc("nop2_T2", E_T2, 5'd0, 1'b1, 1'b0);
    cyc("nop2_T3", M_NONE, 5'd0, 1'b1, 1'b0);

    // Stop sampled in T0 -> HALT, held for 20 cycles regardless of Stop
    Stop = 1'b1;
    cyc("stop_T0", E_T0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      Stop = i[0];
      cyc("halted", M_NONE, 5'd0, 1'b0, 1'b0);
    end
    Stop  = 1'b0;
    clear = 1'b0;
    cyc("halt_rst", M_NONE, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    cyc("halt_rst_state", M_NONE, 5'd0, 1'b1, 1'b0);

    // halt opcode
    ir = {5'b11011, 27'h0};
    fetch("halt");
    cyc("halt_T3", M_NONE, 5'd0, 1'b1, 1'b0);
    cyc("halt_op_state", M_NONE, 5'd0, 1'b0, 1'b0);
    cyc("halt_op_state2", M_NONE, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
    cyc("halt_op_rst", M_NONE, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    cyc("halt_op_rst_state", M_NONE, 5'd0, 1'b1, 1'b0);

    // Reset mid-load during T5
    ir = {5'b00000, 27'h0};
    fetch("abort");
    cyc("abort_T3", E_T3_MEM, 5'd0, 1'b1, 1'b0);
    cyc("abort_T4", E_T4_IMM, 5'b00011, 1'b1, 1'b0);
    clear = 1'b0;
    cyc("abort_T5", M_ZLOWOUT | M_MARIN, 5'd0, 1'b1, 1'b0);
    cyc("abort_rst1", M_NONE, 5'd0, 1'b1, 1'b0);
    clear = 1'b1;
    cyc("abort_rst2", M_NONE, 5'd0, 1'b1, 1'b0);
    run_ld("resume");
    cyc("resume_next_T0", E_T0, 5'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; opcode values are fixed in REQ-027.
REQ-002 Clock  in  1  system clock; all state changes on rising edge.
REQ-003 clear  in  1  synchronous, active-low reset.
REQ-004 ir  in  32  instruction register contents; opcode = ir[31:27].
REQ-005 Stop  in  1  halt request, sampled only in state T0.
REQ-006 PCout, MARin, IncPC, PCin, IRin  out  1 each  PC/MAR/IR strobes.
REQ-007 Read, Write, MDRin, MDRout  out  1 each  memory and MDR strobes.
REQ-008 Yin, Zin, Zlowout, Cout  out  1 each  ALU operand/result strobes.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable strobes.
REQ-010 alu_op  out  5  ALU operation code to datapath.
REQ-011 Run  out  1  high while sequencing, low in HALT.
REQ-012 Illegal  out  1  one-cycle flag for an undefined opcode.

Function
REQ-013 States SHALL be RST, T0-T7 and HALT.
REQ-014 Outputs SHALL be combinational in state and ir[31:27] only; each strobe SHALL be high for exactly the cycle(s) listed and low otherwise.
REQ-015 alu_op SHALL be 0 in every state except T4.
REQ-016 T0: PCout, MARin, IncPC, Zin; next T1, or HALT if Stop=1.
REQ-017 T1: Zlowout, PCin, Read, MDRin; next T2.
REQ-018 T2: MDRout, IRin; next T3 unconditionally.
REQ-019 T3 onward SHALL decode from ir[31:27], which the datapath holds stable from T3 until the next T2.
REQ-020 ld: T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=00011; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; then T0; 8 cycles total.
REQ-021 ldi: T3-T4 as ld; T5 Zlowout,Gra,Rin; then T0; 6 cycles.
REQ-022 st: T3-T5 as ld; T6 Gra,Rout,MDRin with Read=0; T7 Write; then T0; 8 cycles.
REQ-023 add/sub/and/or: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=ir[31:27]; T5 Zlowout,Gra,Rin; then T0; 6 cycles.
REQ-024 addi/andi/ori: T3 Grb,Rout,Yin; T4 Cout,Zin,alu_op = 00011, 00101 or 00110 respectively; T5 Zlowout,Gra,Rin; then T0.
REQ-025 nop: T3 with no strobes; then T0; 4 cycles.
REQ-026 halt: T3 with no strobes; then HALT. Undefined opcode: T3 with no strobes and Illegal=1; then T0.
REQ-027 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011.
REQ-028 HALT SHALL assert no strobes, hold Run=0, ignore Stop, and exit only through reset.
REQ-029 Read and Write SHALL never be high in the same cycle, and Rin and Rout SHALL never be high in the same cycle.

Reset
REQ-030 clear=0 at a rising edge SHALL force RST from any state, including mid-instruction and HALT, aborting the instruction with no further strobes.
REQ-031 In RST all strobes, alu_op and Illegal SHALL be 0 and Run SHALL be 1; the first edge with clear=1 SHALL move RST to T0.

Verification
REQ-032 Reset pulse, then ir=ld (00000) -> strobes exactly per REQ-016..020, alu_op=00011 only in T4, T0 again 8 cycles after the first T0.
REQ-033 ir=add (00011) then sub (00100) -> each takes 6 cycles; alu_op=00011 then 00100 in T4; Grc high only in T4.
REQ-034 ir=st (00010) -> MDRin high in T6 with Read=0, Write high only in T7, Rin never high.
REQ-035 Stop=1 during T1, deasserted before T0 -> no effect; Stop=1 at T0 -> HALT next, Run=0, stays halted for 20 cycles.
REQ-036 clear=0 during T5 of ld -> RST next edge, MARin not asserted again; release -> T0 -> fetch resumes.
REQ-037 ir opcode 11111 -> Illegal=1 for exactly one cycle (T3) with all strobes 0, then T0.
